// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the BRAM-backed FIFOs.
//   OUT_SLOTS   - words held in the output stage (head + skid)
//   fifo_cap()  - total words a FIFO of a given RAM address width can hold
//   fifo_cnt_w()- width of the occupancy counter for that address width
package fifo_pkg;

  localparam int OUT_SLOTS = 2;

  // The RAM holds 2**aw words; the output stage adds OUT_SLOTS more.
  function automatic int fifo_cap(input int addr_width);
    return (1 << addr_width) + OUT_SLOTS;
  endfunction

  // Two extra bits: one for the power-of-two RAM depth, one for the skid slots.
  function automatic int fifo_cnt_w(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/bram_fwft_fifo_bram.sv
// BlockRam: simple dual-port RAM, one write port, one registered read port.
//   clk      - clock, rising edge
//   wr_en    - write strobe; din stored at wr_addr
//   rd_en    - read strobe; data_out loads mem[rd_addr] on the same edge
//   data_out - registered read data, valid after the edge that sampled rd_addr
// No reset on the array or the read register so it maps onto block RAM.
module BlockRam #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
    if (rd_en) data_out     <= mem[rd_addr];
  end

endmodule

// File: rtl/bram_fwft_fifo.sv
// bram_fwft_fifo: first-word-fall-through FIFO on a BlockRam ring plus a
// two-word prefetch stage (head + skid) that hides the registered RAM read.
//   clk, rst_n        - clock; asynchronous active-low reset
//   src_data, wr_en   - push port; rejected while full (wr_err_flr pulses)
//   rd_en             - pop the word on dest_data; rejected while !valid
//                       (rd_err_flr pulses)
//   dest_data, valid  - registered head word and its qualifier; empty = !valid
//   full              - RAM ring full, pushes rejected
//   almost_full/empty - registered threshold flags on data_cnt
//   data_cnt          - words held in RAM + in-flight read + output stage
// Build option: define BRAM_FWFT_FIFO_THRESH_EN to enable the threshold
// flags (and their range check); otherwise both flags are tied low.
module bram_fwft_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dest_data,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_err_flr,
  output logic                  rd_err_flr,
  output logic [ADDR_WIDTH+1:0] data_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CNT_W = fifo_cnt_w(ADDR_WIDTH);
  localparam int CAP   = fifo_cap(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  inflight_q;
  logic [1:0]            out_cnt_q, out_cnt_d, out_ap;
  logic [DATA_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic [CNT_W-1:0]      data_cnt_q, data_cnt_d;
  logic                  wr_err_q, rd_err_q;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [2:0]            occ;
  logic                  push, pop, issue;

  assign full  = (ram_cnt_q == (ADDR_WIDTH+1)'(DEPTH));
  assign valid = (out_cnt_q != 2'd0);
  assign empty = ~valid;
  assign push  = wr_en & ~full;
  assign pop   = rd_en & valid;

  // Words already in, or on their way into, the output stage. Compared as
  // occ < OUT_SLOTS + pop so the subtraction of pop never underflows.
  assign occ   = {1'b0, out_cnt_q} + {2'b00, inflight_q};
  assign issue = (ram_cnt_q != '0) && (occ < (3'(OUT_SLOTS) + {2'b00, pop}));
  assign out_ap = out_cnt_q - {1'b0, pop};

  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(issue);
    ram_cnt_d  = ram_cnt_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
    data_cnt_d = data_cnt_q + CNT_W'(push) - CNT_W'(pop);
    out_cnt_d  = out_ap + {1'b0, inflight_q};
    if (pop && out_cnt_q == 2'd2) head_d = skid_q;
    // The returning RAM word lands wherever the first free slot is once
    // this cycle's pop has been accounted for.
    if (inflight_q) begin
      if (out_ap == 2'd0) head_d = ram_dout;
      else                skid_d = ram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= '0;
      head_q     <= '0;
      skid_q     <= '0;
      data_cnt_q <= '0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= issue;
      out_cnt_q  <= out_cnt_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      data_cnt_q <= data_cnt_d;
      wr_err_q   <= wr_en & full;
      rd_err_q   <= rd_en & ~valid;
    end
  end

  assign dest_data  = head_q;
  assign data_cnt   = data_cnt_q;
  assign wr_err_flr = wr_err_q;
  assign rd_err_flr = rd_err_q;

`ifdef BRAM_FWFT_FIFO_THRESH_EN
  localparam logic [CNT_W-1:0] AF_TH = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_TH = CNT_W'(AEMPTY_THRESH);

  if (!(AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= CAP)) begin : g_thresh_bad
    $error("bram_fwft_fifo: thresholds must satisfy AEMPTY < AFULL <= CAP");
  end

  logic af_q, ae_q;

  // Evaluated on the next-state count so the flags change on the same edge
  // as data_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (data_cnt_d >= AF_TH);
      ae_q <= (data_cnt_d <= AE_TH);
    end
  end

  assign almost_full  = af_q;
  assign almost_empty = ae_q;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

  BlockRam #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .din     (src_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr_q),
    .data_out(ram_dout)
  );

endmodule

// File: tb/tb_bram_fwft_fifo.sv
// Directed bench for bram_fwft_fifo with ADDR_WIDTH=4 (RAM 16, capacity 18).
// Threshold-flag expectations follow BRAM_FWFT_FIFO_THRESH_EN.
module tb_bram_fwft_fifo;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dest_data;
  logic          valid, empty, full, almost_full, almost_empty;
  logic          wr_err_flr, rd_err_flr;
  logic [AW+1:0] data_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bram_fwft_fifo #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (16),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_data    (src_data),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dest_data   (dest_data),
    .valid       (valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .wr_err_flr  (wr_err_flr),
    .rd_err_flr  (rd_err_flr),
    .data_cnt    (data_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_af(input int c);
`ifdef BRAM_FWFT_FIFO_THRESH_EN
    return c >= 16;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ae(input int c);
`ifdef BRAM_FWFT_FIFO_THRESH_EN
    return c <= 2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_cnt(input string tag, input int c);
    chk({tag, ".cnt"}, 64'(data_cnt), 64'(c));
    chk({tag, ".af"},  64'(almost_full), 64'(exp_af(c)));
    chk({tag, ".ae"},  64'(almost_empty), 64'(exp_ae(c)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".valid"}, 64'(valid), 64'd0);
    chk({tag, ".empty"}, 64'(empty), 64'd1);
    chk({tag, ".full"},  64'(full), 64'd0);
    chk({tag, ".dout"},  64'(dest_data), 64'd0);
    chk({tag, ".werr"},  64'(wr_err_flr), 64'd0);
    chk({tag, ".rerr"},  64'(rd_err_flr), 64'd0);
    chk_cnt(tag, 0);
  endtask

  initial begin
    // reset state
    #12;
    chk_reset_state("rst");
    rst_n = 1'b1;

    // single push into empty: count at edge 0, head valid after edge 2
    wr_en = 1'b1; src_data = 32'hA5;
    step();
    chk_cnt("a_push", 1);
    chk("a_v0", 64'(valid), 64'd0);
    wr_en = 1'b0;
    step();
    chk("a_v1", 64'(valid), 64'd0);
    step();
    chk("a_v2", 64'(valid), 64'd1);
    chk("a_dout", 64'(dest_data), 64'hA5);
    chk("a_empty", 64'(empty), 64'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("a_pop_v", 64'(valid), 64'd0);
    chk_cnt("a_pop", 0);

    // pop on empty with a simultaneous push
    rd_en = 1'b1; wr_en = 1'b1; src_data = 32'h11;
    step();
    chk("b_rerr", 64'(rd_err_flr), 64'd1);
    chk("b_werr", 64'(wr_err_flr), 64'd0);
    chk_cnt("b_push", 1);
    rd_en = 1'b0; wr_en = 1'b0;
    step();
    chk("b_rerr_clr", 64'(rd_err_flr), 64'd0);
    step();
    chk("b_v", 64'(valid), 64'd1);
    chk("b_dout", 64'(dest_data), 64'h11);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk_cnt("b_pop", 0);

    // fill to capacity, then overflow
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; src_data = 32'h100 + 32'(i);
      step();
      chk_cnt($sformatf("c_fill%0d", i), i + 1);
      chk($sformatf("c_full%0d", i), 64'(full), 64'(i == 17));
    end
    src_data = 32'h1FF;
    step();
    chk("c_werr", 64'(wr_err_flr), 64'd1);
    chk("c_full", 64'(full), 64'd1);
    chk_cnt("c_ovf", 18);
    wr_en = 1'b0;
    step();
    chk("c_werr_clr", 64'(wr_err_flr), 64'd0);
    chk_cnt("c_hold", 18);

    // drain in order, valid every cycle
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("c_dv%0d", i), 64'(valid), 64'd1);
      chk($sformatf("c_dd%0d", i), 64'(dest_data), 64'h100 + 64'(i));
      rd_en = 1'b1;
      step();
      chk_cnt($sformatf("c_drain%0d", i), 17 - i);
    end
    rd_en = 1'b0;
    chk("c_end_v", 64'(valid), 64'd0);
    chk("c_end_e", 64'(empty), 64'd1);

    // streaming push+pop from 9 held words
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; src_data = 32'h200 + 32'(i);
      step();
    end
    wr_en = 1'b0;
    step();
    step();
    chk_cnt("d_half", 9);
    for (int k = 0; k < 100; k++) begin
      chk($sformatf("d_v%0d", k), 64'(valid), 64'd1);
      chk($sformatf("d_d%0d", k), 64'(dest_data), 64'h200 + 64'(k));
      wr_en = 1'b1; rd_en = 1'b1; src_data = 32'h200 + 32'(9 + k);
      step();
      chk_cnt($sformatf("d_s%0d", k), 9);
    end
    wr_en = 1'b0;
    for (int k = 100; k < 109; k++) begin
      chk($sformatf("d_v%0d", k), 64'(valid), 64'd1);
      chk($sformatf("d_d%0d", k), 64'(dest_data), 64'h200 + 64'(k));
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    chk_cnt("d_end", 0);
    chk("d_end_v", 64'(valid), 64'd0);

    // async reset with 10 words held and a read in flight
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; src_data = 32'h300 + 32'(i);
      step();
    end
    wr_en = 1'b0;
    step();
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk_cnt("e_pre", 9);
    rst_n = 1'b0;
    #1;
    chk_reset_state("e_rst");
    #1;
    rst_n = 1'b1;
    wr_en = 1'b1; src_data = 32'h5A;
    step();
    wr_en = 1'b0;
    chk_cnt("e_push", 1);
    step();
    chk("e_v1", 64'(valid), 64'd0);
    step();
    chk("e_v2", 64'(valid), 64'd1);
    chk("e_dout", 64'(dest_data), 64'h5A);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("e_pop_v", 64'(valid), 64'd0);
    step();
    chk("e_stale_v", 64'(valid), 64'd0);
    chk_cnt("e_end", 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bram_fwft_fifo.md
# bram_fwft_fifo

Synchronous first-word-fall-through FIFO built on the shared `BlockRam` primitive. A two-entry prefetch stage hides the RAM read latency, so the head word is always presented on `dest_data` with `valid`, and a pop costs no extra cycle. Programmable almost-full and almost-empty flags let producers and consumers throttle early. It is the drop-in successor to the standard-mode BRAM FIFO for streaming datapaths.

## Interface
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 10: RAM address width; RAM depth `2**ADDR_WIDTH`; total capacity `CAP = 2**ADDR_WIDTH + 2`.
- `AFULL_THRESH`, `2**ADDR_WIDTH`: `almost_full` asserts when `data_cnt >= AFULL_THRESH`.
- `AEMPTY_THRESH`, 2: `almost_empty` asserts when `data_cnt <= AEMPTY_THRESH`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `src_data`, in, `DATA_WIDTH`: write data.
- `wr_en`, in, 1: push request.
- `rd_en`, in, 1: pop request; consumes the word on `dest_data`.
- `dest_data`, out, `DATA_WIDTH`: head word, registered.
- `valid`, out, 1: `dest_data` holds a word.
- `empty`, out, 1: equals `!valid`.
- `full`, out, 1: the RAM is full; no push accepted.
- `almost_full`, `almost_empty`, out, 1: threshold flags.
- `wr_err_flr`, `rd_err_flr`, out, 1: one-cycle pulse flagging a rejected push or pop.
- `data_cnt`, out, `ADDR_WIDTH+2`: total words held, counting RAM, in-flight read and output slots.

## Operation
- Storage: RAM ring with `wr_ptr`/`rd_ptr` (`ADDR_WIDTH` bits, natural wrap) and `ram_cnt` (`ADDR_WIDTH+1` bits).
- `full = (ram_cnt == 2**ADDR_WIDTH)`.
- Output stage: head register plus skid register; `out_cnt` is 0..2.
- `inflight` is set when a RAM read was issued on the previous edge.
- Push is accepted when `wr_en && !full`. Otherwise `wr_err_flr` pulses and the RAM write enable stays low.
- Pop is accepted when `rd_en && valid`. Otherwise `rd_err_flr` pulses and state is unchanged.
- A pop and a push in the same cycle are evaluated against pre-edge state:
  - a push while full is rejected even if a pop is accepted;
  - a pop while empty is rejected even if a push is accepted.
- Prefetch issue condition: `ram_cnt != 0 && (out_cnt + inflight - pop) < 2`.
- On issue, `rd_ptr` increments and `ram_cnt` decrements.
- On the next edge, `BlockRam.data_out` is captured:
  - into the head register if the head is free after the pop;
  - otherwise into the skid register.
- On a pop with the skid register occupied, the skid word moves to the head.
- `data_cnt` increments on an accepted push, decrements on an accepted pop, and is unchanged when both occur.
- Reset (async assert): all pointers, counts, `inflight` and `out_cnt` go to 0. Outputs after reset:
  - `valid=0`, `empty=1`, `full=0`, `data_cnt=0`;
  - `almost_empty=1`, `almost_full=0`;
  - both error flags 0;
  - `dest_data=0`.
- Reset asserted mid-transfer discards all contents, including any in-flight read. Reset deassertion is synchronised externally.

## Timing
- `BlockRam` read is registered: the address sampled at edge N gives data valid after edge N.
- Push into an empty FIFO accepted at edge N:
  - prefetch issues at edge N+1;
  - head captured at edge N+2;
  - `valid=1` after N+2.
- `data_cnt`, `full` and the error flags update at the edge of the event.
- Threshold flags are registered and lag `data_cnt` by 0 cycles (computed from next-state count).
- Sustained throughput is one push and one pop per cycle, with no bubbles once `out_cnt == 2`.
- Read/write to the same RAM address in one cycle cannot occur: issue requires `ram_cnt != 0`, which already reflects the prior write.

## Configuration
- `BRAM_FWFT_FIFO_THRESH_EN`:
  - **Defined:** `almost_full`/`almost_empty` are computed from `AFULL_THRESH`/`AEMPTY_THRESH`, and the thresholds are range-checked at elaboration (`AEMPTY_THRESH < AFULL_THRESH <= CAP`).
  - **Undefined:** both flags are tied to 0, the threshold parameters are ignored, and there are no comparators.

## Structure
- Shared package `fifo_pkg`:
  - capacity function `fifo_cap(addr_width)`;
  - count-width constant rule (`ADDR_WIDTH+2`);
  - output-stage slot constant `OUT_SLOTS = 2`.
- One sub-module: the existing `BlockRam` (`DATA_WIDTH`, `ADDR_WIDTH`), with its `wr_en` driven only by accepted pushes.

## Test plan
All scenarios use `ADDR_WIDTH=4`, so `CAP=18`.
- Single push of `0xA5` into an empty FIFO at edge 0 → `valid=1`, `dest_data=0xA5` after edge 2; `data_cnt=1` after edge 0.
- 18 back-to-back pushes with no pops → `full=1`, `data_cnt=18` after the 18th; a 19th push → `wr_err_flr` pulses 1 cycle, count stays 18.
- Pop on an empty FIFO → `rd_err_flr` pulses, `data_cnt` stays 0; a simultaneous push is still accepted.
- Continuous push and pop for 100 cycles of an incrementing pattern from a half-full state → output in order, no gaps, `data_cnt` constant.
- With the macro defined, `AFULL_THRESH=16`, `AEMPTY_THRESH=2`: fill to 16 → `almost_full=1`; drain to 2 → `almost_empty=1`. Without the macro, both flags stay 0.
- `rst_n` pulsed low while 10 words are held and a read is in flight → all outputs return to reset values immediately, and the next push reappears after 2 edges.
